// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared constants and types for the PlayStation-2 pad receiver:
//   - command bytes sent on the COMMAND line during a poll
//   - ACK byte and accepted pad IDs used to validate a response
//   - FSM state encoding of the transaction sequencer
//   - bit positions of each button inside the decoded 10-bit button word
// ----------------------------------------------------------------------------
package ps2_pkg;

  localparam logic [7:0] CMD_START  = 8'h01;
  localparam logic [7:0] CMD_POLL   = 8'h42;
  localparam logic [7:0] CMD_IDLE   = 8'h00;

  localparam logic [7:0] ACK        = 8'h5A;
  localparam logic [7:0] ID_DIGITAL = 8'h41;
  localparam logic [7:0] ID_ANALOG  = 8'h73;

  localparam int NUM_BYTES = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_GAP,
    ST_CS_HOLD,
    ST_UPDATE
  } ps2_state_e;

  // Positions in the decoded (active-high) button word
  localparam int BTN_SELECT   = 9;
  localparam int BTN_START    = 8;
  localparam int BTN_UP       = 7;
  localparam int BTN_RIGHT    = 6;
  localparam int BTN_DOWN     = 5;
  localparam int BTN_LEFT     = 4;
  localparam int BTN_TRIANGLE = 3;
  localparam int BTN_CIRCLE   = 2;
  localparam int BTN_CROSS    = 1;
  localparam int BTN_SQUARE   = 0;

  // Command byte transmitted in transaction slot idx
  function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return CMD_START;
      3'd1:    return CMD_POLL;
      default: return CMD_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ps2_tick_gen.sv
// ----------------------------------------------------------------------------
// ps2_tick_gen
// Free-running timebase for the pad link.
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   o_tick   one-cycle pulse every HALF_BIT_CYC cycles (SCK half period)
//   o_trig   one-cycle pulse every FRAME_CYC cycles (poll start request);
//            the first pulse falls on the FRAME_CYC-th edge after reset
// ----------------------------------------------------------------------------
module ps2_tick_gen #(
  parameter int HALF_BIT_CYC = 300,
  parameter int FRAME_CYC    = 51000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick,
  output logic o_trig
);

  localparam int HALF_W  = (HALF_BIT_CYC > 1) ? $clog2(HALF_BIT_CYC) : 1;
  localparam int FRAME_W = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;

  logic [HALF_W-1:0]  r_half;
  logic [FRAME_W-1:0] r_frame;
  logic               w_tick;
  logic               w_trig;

  assign w_tick = (r_half == HALF_W'(HALF_BIT_CYC - 1));
  assign w_trig = (r_frame == FRAME_W'(FRAME_CYC - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_half  <= '0;
      r_frame <= '0;
    end else begin
      r_half  <= w_tick ? '0 : r_half + 1'b1;
      r_frame <= w_trig ? '0 : r_frame + 1'b1;
    end
  end

  assign o_tick = w_tick;
  assign o_trig = w_trig;

endmodule

// File: rtl/ps2_recv.sv
// ----------------------------------------------------------------------------
// ps2_recv
// Periodically polls a PlayStation-2 pad and publishes its buttons.
//   sys_clk   system clock (rising edge)
//   rst       asynchronous active-low reset
//   spi_miso  pad DATA, sampled on SCK rising edge, LSB first
//   smosi     pad COMMAND, LSB first, 1 when idle
//   scs       pad ATTENTION, active low
//   sclk      pad CLOCK, idle high
//   data      decoded buttons, active high (layout in ps2_pkg BTN_*)
//   ledout    inverse of response byte 4 for an LED bring-up mirror
// A frame is accepted only if ACK and pad ID check out; otherwise the
// previously published buttons are kept.
// ----------------------------------------------------------------------------
module ps2_recv
  import ps2_pkg::*;
#(
  parameter int HALF_BIT_CYC = 300,
  parameter int FRAME_CYC    = 51000,
  parameter int GAP_HALVES   = 2
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       spi_miso,
  output logic       smosi,
  output logic       scs,
  output logic       sclk,
  output logic [9:0] data,
  output logic [7:0] ledout
);

  localparam int GAP_W = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;

  logic             w_tick;
  logic             w_trig;
  ps2_state_e       r_state;
  ps2_state_e       w_next;
  logic             r_scs, r_sclk, r_smosi;
  logic             w_scs_n, w_sclk_n, w_smosi_n;
  logic [2:0]       r_bit;
  logic [2:0]       r_byte;
  logic [GAP_W-1:0] r_gap;
  logic [7:0]       w_cmd;
  logic             r_miso_s1, r_miso_s2;
  logic [7:0]       r_shift;
  logic [7:0]       r_r1, r_r2, r_r3, r_r4;
  logic             w_shift_en;
  logic             w_byte_done;
  logic             w_valid;
  logic [9:0]       w_buttons;
  logic [9:0]       r_data;
  logic [7:0]       r_led;
  logic             w_unused_r3;

  ps2_tick_gen #(
    .HALF_BIT_CYC (HALF_BIT_CYC),
    .FRAME_CYC    (FRAME_CYC)
  ) u_tick (
    .i_clk   (sys_clk),
    .i_rst_n (rst),
    .o_tick  (w_tick),
    .o_trig  (w_trig)
  );

  assign w_cmd       = cmd_byte(r_byte);
  assign w_shift_en  = (r_state == ST_BIT_LOW) && w_tick;
  assign w_byte_done = (r_state == ST_BIT_HIGH) && w_tick && (r_bit == 3'd7);

  // Next state plus the pad-line values to present from that state on.
  // A trig outside IDLE is simply not looked at.
  always_comb begin
    w_next    = r_state;
    w_scs_n   = r_scs;
    w_sclk_n  = r_sclk;
    w_smosi_n = r_smosi;
    case (r_state)
      ST_IDLE: begin
        if (w_trig) begin
          w_next  = ST_CS_SETUP;
          w_scs_n = 1'b0;
        end
      end
      ST_CS_SETUP: begin
        if (w_tick) begin
          w_next    = ST_BIT_LOW;
          w_sclk_n  = 1'b0;
          w_smosi_n = w_cmd[0];
        end
      end
      ST_BIT_LOW: begin
        if (w_tick) begin
          w_next   = ST_BIT_HIGH;
          w_sclk_n = 1'b1;
        end
      end
      ST_BIT_HIGH: begin
        if (w_tick) begin
          if (r_bit != 3'd7) begin
            w_next    = ST_BIT_LOW;
            w_sclk_n  = 1'b0;
            w_smosi_n = w_cmd[r_bit + 3'd1];
          end else if (r_byte != 3'(NUM_BYTES - 1)) begin
            w_next    = ST_GAP;
            w_smosi_n = 1'b1;
          end else begin
            w_next    = ST_CS_HOLD;
            w_smosi_n = 1'b1;
          end
        end
      end
      ST_GAP: begin
        // r_byte already points at the next byte here
        if (w_tick && (r_gap == GAP_W'(GAP_HALVES - 1))) begin
          w_next    = ST_BIT_LOW;
          w_sclk_n  = 1'b0;
          w_smosi_n = w_cmd[0];
        end
      end
      ST_CS_HOLD: begin
        if (w_tick) begin
          w_next  = ST_UPDATE;
          w_scs_n = 1'b1;
        end
      end
      ST_UPDATE: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Pad lines are registered so they never glitch
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_scs   <= 1'b1;
      r_sclk  <= 1'b1;
      r_smosi <= 1'b1;
    end else begin
      r_scs   <= w_scs_n;
      r_sclk  <= w_sclk_n;
      r_smosi <= w_smosi_n;
    end
  end

  // Bit/byte/gap position inside the transaction
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_bit  <= '0;
      r_byte <= '0;
      r_gap  <= '0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_bit  <= '0;
        r_byte <= '0;
      end else if ((r_state == ST_BIT_HIGH) && w_tick) begin
        if (r_bit == 3'd7) begin
          r_bit  <= '0;
          r_byte <= r_byte + 3'd1;
        end else begin
          r_bit <= r_bit + 3'd1;
        end
      end
      if (r_state != ST_GAP) begin
        r_gap <= '0;
      end else if (w_tick) begin
        r_gap <= r_gap + 1'b1;
      end
    end
  end

  // MISO is asynchronous to sys_clk: two-flop synchroniser. The pad changes
  // DATA on SCK fall, so the synchronised copy has settled long before the
  // SCK rise where it is shifted in. R0 is never kept.
  always_ff @(posedge sys_clk) begin
    r_miso_s1 <= spi_miso;
    r_miso_s2 <= r_miso_s1;
    if (w_shift_en) begin
      r_shift <= {r_miso_s2, r_shift[7:1]};
    end
    if (w_byte_done) begin
      case (r_byte)
        3'd1:    r_r1 <= r_shift;
        3'd2:    r_r2 <= r_shift;
        3'd3:    r_r3 <= r_shift;
        3'd4:    r_r4 <= r_shift;
        default: ;
      endcase
    end
  end

  assign w_valid = (r_r2 == ACK) && ((r_r1 == ID_DIGITAL) || (r_r1 == ID_ANALOG));

  // Response bits are active low; R3[2:1] are the stick clicks, not published
  always_comb begin
    w_buttons               = '0;
    w_buttons[BTN_SELECT]   = ~r_r3[0];
    w_buttons[BTN_START]    = ~r_r3[3];
    w_buttons[BTN_UP]       = ~r_r3[4];
    w_buttons[BTN_RIGHT]    = ~r_r3[5];
    w_buttons[BTN_DOWN]     = ~r_r3[6];
    w_buttons[BTN_LEFT]     = ~r_r3[7];
    w_buttons[BTN_TRIANGLE] = ~r_r4[4];
    w_buttons[BTN_CIRCLE]   = ~r_r4[5];
    w_buttons[BTN_CROSS]    = ~r_r4[6];
    w_buttons[BTN_SQUARE]   = ~r_r4[7];
  end

  assign w_unused_r3 = ^r_r3[2:1];

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
      r_led  <= '0;
    end else if ((r_state == ST_UPDATE) && w_valid) begin
      r_data <= w_buttons;
      r_led  <= ~r_r4;
    end
  end

  assign scs    = r_scs;
  assign sclk   = r_sclk;
  assign smosi  = r_smosi;
  assign data   = r_data;
  assign ledout = r_led;

endmodule

// File: tb/tb_ps2_recv.sv
// ----------------------------------------------------------------------------
// tb_ps2_recv
// Bench for ps2_recv with HALF_BIT_CYC=4, FRAME_CYC=1000, GAP_HALVES=2.
// A pad model answers each poll with the bytes in tx_bytes, changing DATA on
// SCK falling edges. Expected {before, after} output pairs are queued when a
// frame is scheduled; a monitor pops one per ATTENTION rise and compares.
// A second monitor captures COMMAND at SCK rises and checks the poll bytes.
// ----------------------------------------------------------------------------
module tb_ps2_recv;

  localparam int HALF  = 4;
  localparam int FRAME = 1000;
  localparam int GAP   = 2;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b0;
  logic       spi_miso = 1'b1;
  logic       smosi;
  logic       scs;
  logic       sclk;
  logic [9:0] data;
  logic [7:0] ledout;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]  tx_bytes [5];
  logic [35:0] exp_q [$];
  logic [17:0] model_out = '0;

  always #5 sys_clk = ~sys_clk;

  ps2_recv #(
    .HALF_BIT_CYC (HALF),
    .FRAME_CYC    (FRAME),
    .GAP_HALVES   (GAP)
  ) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .spi_miso (spi_miso),
    .smosi    (smosi),
    .scs      (scs),
    .sclk     (sclk),
    .data     (data),
    .ledout   (ledout)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: pressed buttons from the pad's active-low bytes, or hold
  function automatic logic [17:0] ref_decode(input logic [7:0] r1, input logic [7:0] r2,
                                             input logic [7:0] r3, input logic [7:0] r4,
                                             input logic [17:0] prev);
    logic [9:0] btn;
    if (r2 != 8'h5A || !(r1 == 8'h41 || r1 == 8'h73)) return prev;
    btn = {~r3[0], ~r3[3], ~r3[4], ~r3[5], ~r3[6], ~r3[7], ~r4[4], ~r4[5], ~r4[6], ~r4[7]};
    return {btn, ~r4};
  endfunction

  task automatic load(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      input logic [7:0] b3, input logic [7:0] b4);
    tx_bytes[0] = b0; tx_bytes[1] = b1; tx_bytes[2] = b2;
    tx_bytes[3] = b3; tx_bytes[4] = b4;
  endtask

  task automatic expect_frame(input logic [17:0] nxt);
    exp_q.push_back({model_out, nxt});
    model_out = nxt;
  endtask

  // Cycles (edges) until scs reaches lvl, sampled 1 time unit after each edge
  task automatic wait_scs(input logic lvl, input int budget, output bit ok, output int n);
    ok = 1'b0;
    n  = budget;
    for (int i = 1; i <= budget; i++) begin
      @(posedge sys_clk);
      #1;
      if (scs == lvl) begin
        ok = 1'b1;
        n  = i;
        break;
      end
    end
  endtask

  task automatic run_frame(input string name);
    bit ok;
    int n;
    wait_scs(1'b0, FRAME + 100, ok, n);
    check({name, "_scs_fall"}, 32'(ok), 32'd1);
    wait_scs(1'b1, 600, ok, n);
    check({name, "_scs_rise"}, 32'(ok), 32'd1);
    repeat (3) @(posedge sys_clk);
  endtask

  // Pad model
  initial begin
    logic [7:0] frame [5];
    int k;
    forever begin
      @(negedge scs);
      frame = tx_bytes;
      k = 0;
      while (scs == 1'b0) begin
        @(negedge sclk or posedge scs);
        if (scs == 1'b0 && k < 40) begin
          spi_miso = frame[k / 8][k % 8];
          k++;
        end
      end
      spi_miso = 1'b1;
    end
  end

  // COMMAND line monitor
  initial begin
    logic [7:0] cap [5];
    logic [7:0] cmd_exp [5];
    int n;
    cmd_exp[0] = 8'h01; cmd_exp[1] = 8'h42; cmd_exp[2] = 8'h00;
    cmd_exp[3] = 8'h00; cmd_exp[4] = 8'h00;
    forever begin
      @(negedge scs);
      n = 0;
      for (int i = 0; i < 5; i++) cap[i] = 8'h00;
      while (scs == 1'b0) begin
        @(posedge sclk or posedge scs);
        if (scs == 1'b0 && sclk == 1'b1) begin
          if (n < 40) cap[n / 8][n % 8] = smosi;
          n++;
        end
      end
      if (rst) begin
        check("sck_rises_per_txn", 32'(n), 32'd40);
        for (int i = 0; i < 5; i++)
          check($sformatf("cmd_byte%0d", i), {24'd0, cap[i]}, {24'd0, cmd_exp[i]});
      end
    end
  end

  // Output monitor: one expected pair per completed transaction
  initial begin
    logic [35:0] e;
    forever begin
      @(posedge scs);
      if (rst) begin
        if (exp_q.size() == 0) begin
          check("unexpected_update", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          #1;
          check("hold_until_update", {14'd0, data, ledout}, {14'd0, e[35:18]});
          @(posedge sys_clk);
          #1;
          check("frame_update", {14'd0, data, ledout}, {14'd0, e[17:0]});
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    int cnt;
    logic prev_sclk;
    logic [7:0] r1, r2, r3, r4;

    // Reset state
    #23;
    check("rst_scs", 32'(scs), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd1);
    check("rst_smosi", 32'(smosi), 32'd1);
    check("rst_data", 32'(data), 32'd0);
    check("rst_ledout", 32'(ledout), 32'd0);

    // Valid digital frame: UP and CROSS
    load(8'hFF, 8'h41, 8'h5A, 8'hEF, 8'hBF);
    expect_frame({10'b0010000010, 8'b01000000});
    @(negedge sys_clk);
    rst = 1'b1;
    wait_scs(1'b0, FRAME + 100, ok, n);
    check("first_poll_cycles", 32'(n), 32'd1000);
    wait_scs(1'b1, 600, ok, n);
    check("txn_len_in_range", 32'(ok && n >= 89 * HALF && n <= 90 * HALF), 32'd1);
    check("smosi_idle_after_txn", 32'(smosi), 32'd1);
    repeat (3) @(posedge sys_clk);

    // No pad: DATA stuck high, outputs must hold
    load(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    expect_frame(model_out);
    run_frame("stuck_high");

    // Analog ID: START, SELECT, SQUARE
    load(8'hFF, 8'h73, 8'h5A, 8'hF6, 8'h7F);
    expect_frame({10'b1100000001, 8'b10000000});
    run_frame("analog");

    // Randomised frames
    for (int f = 0; f < 12; f++) begin
      if ($urandom_range(0, 7) == 0) begin
        r1 = 8'hFF; r2 = 8'hFF; r3 = 8'hFF; r4 = 8'hFF;
      end else begin
        n  = $urandom_range(0, 9);
        r1 = (n < 4) ? 8'h41 : (n < 8) ? 8'h73 : 8'($urandom);
        r2 = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h5A;
        r3 = 8'($urandom);
        r4 = 8'($urandom);
      end
      load(8'hFF, r1, r2, r3, r4);
      expect_frame(ref_decode(r1, r2, r3, r4, model_out));
      run_frame("random");
    end

    // Reset in the middle of byte 2: nothing is queued for this frame
    load(8'hFF, 8'h41, 8'h5A, 8'h00, 8'h00);
    wait_scs(1'b0, FRAME + 100, ok, n);
    check("midrst_scs_fall", 32'(ok), 32'd1);
    cnt = 0;
    prev_sclk = sclk;
    for (int i = 0; i < 400 && cnt < 20; i++) begin
      @(posedge sys_clk);
      #1;
      if (sclk && !prev_sclk) cnt++;
      prev_sclk = sclk;
    end
    check("midrst_reached_byte2", 32'(cnt), 32'd20);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_scs", 32'(scs), 32'd1);
    check("midrst_sclk", 32'(sclk), 32'd1);
    check("midrst_smosi", 32'(smosi), 32'd1);
    check("midrst_data", 32'(data), 32'd0);
    check("midrst_ledout", 32'(ledout), 32'd0);
    model_out = '0;
    repeat (5) @(posedge sys_clk);

    r3 = 8'($urandom);
    r4 = 8'($urandom);
    load(8'hFF, 8'h73, 8'h5A, r3, r4);
    expect_frame(ref_decode(8'h73, 8'h5A, r3, r4, model_out));
    @(negedge sys_clk);
    rst = 1'b1;
    wait_scs(1'b0, FRAME + 100, ok, n);
    check("poll_after_midrst_cycles", 32'(n), 32'd1000);
    wait_scs(1'b1, 600, ok, n);
    check("post_rst_scs_rise", 32'(ok), 32'd1);
    repeat (3) @(posedge sys_clk);

    // One more random frame after recovery
    r1 = 8'h41; r2 = 8'h5A; r3 = 8'($urandom); r4 = 8'($urandom);
    load(8'hFF, r1, r2, r3, r4);
    expect_frame(ref_decode(r1, r2, r3, r4, model_out));
    run_frame("final");

    repeat (10) @(posedge sys_clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ps2_recv.md
# ps2_recv

PlayStation-2 gamepad receiver. It polls the pad periodically over its SPI-like link (SCK, command, attention, data) and decodes the returned button bytes. It presents the decoded buttons as registered, active-high outputs. It sits between the board pad connector and the game/control logic, with an 8-bit LED mirror for bring-up.

## Interface
Parameters:
- HALF_BIT_CYC, 300: sys_clk cycles per SCK half-period (6 µs at 50 MHz).
- FRAME_CYC, 51000: sys_clk cycles between poll starts (1020 µs at 50 MHz); must exceed one full transaction.
- GAP_HALVES, 2: idle half-bit ticks between bytes, SCK high.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- spi_miso  in  1  pad DATA line, sampled on SCK rising edge.
- smosi  out  1  pad COMMAND line, LSB first.
- scs  out  1  pad ATTENTION, active low.
- sclk  out  1  pad CLOCK, idle high.
- data  out  10  decoded buttons, active-high: [9] SELECT, [8] START, [7] UP, [6] RIGHT, [5] DOWN, [4] LEFT, [3] TRIANGLE, [2] CIRCLE, [1] CROSS, [0] SQUARE.
- ledout  out  8  bitwise inverse of response byte 4: [7] SQUARE, [6] CROSS, [5] CIRCLE, [4] TRIANGLE, [3] R1, [2] L1, [1] R2, [0] L2.

## Operation
- Tick divider: a one-cycle `tick` every HALF_BIT_CYC cycles. A frame counter raises `trig` every FRAME_CYC cycles.
- Transaction: 5 bytes.
  - Command bytes: 0x01, 0x42, 0x00, 0x00, 0x00.
  - Response bytes R0..R4: R1 is the pad ID, R2 must be 0x5A, R3 and R4 are active-low buttons.
- FSM states: IDLE, CS_SETUP, BIT_LOW, BIT_HIGH, GAP, CS_HOLD, UPDATE.
- FSM transitions:
  - IDLE → CS_SETUP on `trig`: scs=0.
  - CS_SETUP → BIT_LOW after 1 tick.
  - BIT_LOW: sclk=0; smosi = command bit (bit index 0 first) set on entry. After 1 tick → BIT_HIGH.
  - BIT_HIGH: sclk=1; spi_miso is shifted in (LSB first) on entry. After 1 tick:
    - → BIT_LOW if the byte is unfinished;
    - → GAP after bit 7 of bytes 0–3;
    - → CS_HOLD after byte 4.
  - GAP: lasts GAP_HALVES ticks → BIT_LOW of the next byte.
  - CS_HOLD: 1 tick, then scs=1 → UPDATE.
  - UPDATE: 1 cycle → IDLE.
- Validity check in UPDATE: the frame is valid if R2 == 0x5A and R1 ∈ {0x41, 0x73}.
- If valid:
  - data = {~R3[0], ~R3[3], ~R3[4], ~R3[5], ~R3[6], ~R3[7], ~R4[4], ~R4[5], ~R4[6], ~R4[7]}.
  - ledout = ~{R4[0..7]} mapped as in the port list.
- If invalid (including no pad, MISO stuck high → R2 = 0xFF): data and ledout hold their previous values.
- A `trig` arriving while not in IDLE is ignored; the frame counter keeps free-running.

## Timing
- Reset values: data=0, ledout=0, scs=1, sclk=1, smosi=1, FSM IDLE, counters 0.
- Reset mid-transaction: outputs return to their reset values immediately (asynchronously). The next poll starts after a full FRAME_CYC.
- The first `trig` occurs FRAME_CYC cycles after reset release.
- Bit period is 2·HALF_BIT_CYC cycles; smosi is stable at least HALF_BIT_CYC cycles before each SCK rising edge.
- Transaction length:
  - tick units: 1 + 5·16 + 4·GAP_HALVES + 1 ticks;
  - cycles: ≈ (82 + 4·GAP_HALVES)·HALF_BIT_CYC.
- Output latency: data/ledout update exactly 1 sys_clk cycle after scs rises, and hold constant until the next UPDATE.
- smosi is 1 outside transactions.

## Structure
- Shared package `ps2_pkg`:
  - command byte constants (0x01, 0x42, 0x00);
  - ACK 0x5A;
  - valid IDs 0x41, 0x73;
  - FSM state enum;
  - button bit-index constants.
- One natural sub-module, `ps2_tick_gen`: the HALF_BIT_CYC tick divider plus the FRAME_CYC trig counter.
- Shift registers and FSM stay in the top level.

## Test plan
Use a small configuration: HALF_BIT_CYC=4, FRAME_CYC=1000. A bench pad model drives spi_miso on SCK falling edges.
- Reset: hold rst=0 → data=0, ledout=0, scs=1, sclk=1, smosi=1. Release → first scs fall at cycle 1000.
- Command check: the captured smosi bytes (sampled at SCK rise, LSB first) = 0x01, 0x42, 0x00, 0x00, 0x00. Exactly 40 SCK rising edges occur while scs=0.
- Valid frame: pad returns FF, 41, 5A, 0xEF, 0xBF (UP and CROSS pressed) → data=10'b0010000010, ledout=8'b01000000, 1 cycle after scs rises.
- Invalid frame: spi_miso tied 1 → after a prior valid frame, data and ledout keep their previous values.
- Analog ID: R1=0x73, R3=0xF6, R4=0x7F (START, SELECT, SQUARE) → data=10'b1100000001, ledout=8'b10000000.
- Reset mid-frame: assert rst during byte 2 → scs=1 and sclk=1 immediately. No UPDATE occurs. The next transaction starts 1000 cycles after release.
